frame_scanner: RTL and testbench

//  Raster sequencer that sits between the Graphics pixel shader and the LT24 LCD write port.
//  - On each frame request it walks every screen coordinate, x fastest.
//  - For each coordinate it drives pixel_x/pixel_y into Graphics and waits out Graphics' latency.
//  - It then captures pixel_rgb and writes it to the display with a write/ready handshake.
//  - It reports frame completion back to the game logic as a one-cycle sync pulse.

---
 rtl/pong_pkg.sv | 15 +
 rtl/xy_raster_counter.sv | 42 ++++
 rtl/frame_scanner.sv | 127 ++++++++++++
 tb/tb_frame_scanner.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Screen geometry and the scanner state encoding used by the pong display path.
package pong_pkg;
    localparam int unsigned SCREEN_W = 240;
    localparam int unsigned SCREEN_H = 320;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned RGB_W    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite
    } scan_state_e;
endpackage

// File: rtl/xy_raster_counter.sv
// Raster x/y counter: x fastest, wraps to the next line at WIDTH-1 and back to the
// origin after the last pixel of the frame.
module xy_raster_counter
    import pong_pkg::*;
#(
    parameter int unsigned WIDTH  = SCREEN_W,
    parameter int unsigned HEIGHT = SCREEN_H
) (
    input  logic           i_clock,
    input  logic           i_reset_n,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);
    localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_x_end;

    assign w_x_end = (r_x == X_MAX);
    assign o_last  = w_x_end && (r_y == Y_MAX);
    assign o_x     = r_x;
    assign o_y     = r_y;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear || (i_advance && o_last)) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_scanner.sv
// Raster sequencer: walks every screen coordinate through the pixel shader, waits out its
// latency, then writes the captured colour to the LCD with a write/ready handshake.
module frame_scanner
    import pong_pkg::*;
#(
    parameter int unsigned WIDTH       = SCREEN_W,
    parameter int unsigned HEIGHT      = SCREEN_H,
    parameter int unsigned GFX_LATENCY = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_frame_start,
    output logic [X_W-1:0]   o_pixel_x,
    output logic [Y_W-1:0]   o_pixel_y,
    input  logic [RGB_W-1:0] i_pixel_rgb,
    output logic [X_W-1:0]   o_lcd_x,
    output logic [Y_W-1:0]   o_lcd_y,
    output logic [RGB_W-1:0] o_lcd_data,
    output logic             o_lcd_write,
    input  logic             i_lcd_ready,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_frame_missed
);
    // WAIT counts down from GFX_LATENCY-1 to 0, giving exactly GFX_LATENCY cycles.
    localparam logic [2:0] WAIT_LOAD = (GFX_LATENCY == 0) ? 3'd0 : 3'(GFX_LATENCY - 1);

    scan_state_e      r_state;
    scan_state_e      w_state_next;
    logic [2:0]       r_wait_cnt;
    logic [X_W-1:0]   r_lcd_x;
    logic [Y_W-1:0]   r_lcd_y;
    logic [RGB_W-1:0] r_lcd_data;
    logic             r_frame_done;
    logic             r_frame_missed;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_last;
    logic             w_clear;
    logic             w_accept;
    logic             w_capture;

    xy_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_xy (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_frame_start) begin
                    w_clear      = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                if (GFX_LATENCY == 0) begin
                    w_capture    = 1'b1;
                    w_state_next = StWrite;
                end else begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_wait_cnt == 3'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                if (i_lcd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = w_last ? StIdle : StIssue;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= StIdle;
            r_wait_cnt     <= 3'd0;
            r_lcd_x        <= '0;
            r_lcd_y        <= '0;
            r_lcd_data     <= '0;
            r_frame_done   <= 1'b0;
            r_frame_missed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIssue) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == StWait) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_capture) begin
                r_lcd_x    <= w_x;
                r_lcd_y    <= w_y;
                r_lcd_data <= i_pixel_rgb;
            end
            r_frame_done   <= w_accept && w_last;
            r_frame_missed <= i_frame_start && (r_state != StIdle);
        end
    end

    assign o_pixel_x      = w_x;
    assign o_pixel_y      = w_y;
    assign o_lcd_x        = r_lcd_x;
    assign o_lcd_y        = r_lcd_y;
    assign o_lcd_data     = r_lcd_data;
    assign o_lcd_write    = (r_state == StWrite);
    assign o_busy         = (r_state != StIdle);
    assign o_frame_done   = r_frame_done;
    assign o_frame_missed = r_frame_missed;
endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: three instances (4x3 latency 1, defaults, 240x4 latency 0), each
// compared every cycle against a pixel-index model of the expected LCD write stream.
`timescale 1ns/1ps
module tb_frame_scanner;
    import pong_pkg::*;

    localparam int NI = 3;
    localparam int unsigned CFG_W [NI] = '{4, 240, 240};
    localparam int unsigned CFG_H [NI] = '{3, 320, 4};
    localparam int unsigned CFG_L [NI] = '{1, 0, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NI];
    logic        fs    [NI];
    logic        rdy   [NI];
    logic [7:0]  px    [NI];
    logic [8:0]  py    [NI];
    logic [7:0]  lx    [NI];
    logic [8:0]  ly    [NI];
    logic [15:0] ld    [NI];
    logic        lw    [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic        miss  [NI];
    logic [15:0] rgb0, rgb1, rgb2;

    // Stub shader: colour = {y[7:0], x}, one register stage for the latency-1 instance.
    always @(posedge clk) rgb0 <= {py[0][7:0], px[0]};
    assign rgb1 = {py[1][7:0], px[1]};
    assign rgb2 = {py[2][7:0], px[2]};

    frame_scanner #(.WIDTH(4), .HEIGHT(3), .GFX_LATENCY(1)) dut_s (
        .i_clock(clk), .i_reset_n(rst_n[0]), .i_frame_start(fs[0]),
        .o_pixel_x(px[0]), .o_pixel_y(py[0]), .i_pixel_rgb(rgb0),
        .o_lcd_x(lx[0]), .o_lcd_y(ly[0]), .o_lcd_data(ld[0]), .o_lcd_write(lw[0]),
        .i_lcd_ready(rdy[0]), .o_busy(busy[0]), .o_frame_done(done[0]),
        .o_frame_missed(miss[0])
    );

    frame_scanner #(.GFX_LATENCY(0)) dut_d (
        .i_clock(clk), .i_reset_n(rst_n[1]), .i_frame_start(fs[1]),
        .o_pixel_x(px[1]), .o_pixel_y(py[1]), .i_pixel_rgb(rgb1),
        .o_lcd_x(lx[1]), .o_lcd_y(ly[1]), .o_lcd_data(ld[1]), .o_lcd_write(lw[1]),
        .i_lcd_ready(rdy[1]), .o_busy(busy[1]), .o_frame_done(done[1]),
        .o_frame_missed(miss[1])
    );

    frame_scanner #(.HEIGHT(4), .GFX_LATENCY(0)) dut_w (
        .i_clock(clk), .i_reset_n(rst_n[2]), .i_frame_start(fs[2]),
        .o_pixel_x(px[2]), .o_pixel_y(py[2]), .i_pixel_rgb(rgb2),
        .o_lcd_x(lx[2]), .o_lcd_y(ly[2]), .o_lcd_data(ld[2]), .o_lcd_write(lw[2]),
        .i_lcd_ready(rdy[2]), .o_busy(busy[2]), .o_frame_done(done[2]),
        .o_frame_missed(miss[2])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, i, act, exp);
        end
    endtask

    task automatic expired(input string name, input int i);
        n_tests++;
        n_fail++;
        $display("FAIL %s[%0d]: wait expired, got no event, expected one", name, i);
    endtask

    // Model state: k is the index of the next pixel the display must receive.
    int   cyc = 0;
    int   k         [NI];
    bit   m_busy    [NI];
    bit   m_done    [NI];
    bit   m_miss    [NI];
    bit   m_zero    [NI] = '{1'b1, 1'b1, 1'b1};
    bit   m_stall   [NI];
    bit   m_clean   [NI];
    int   busy_cyc  [NI];
    int   last_acc  [NI];
    int   frame_len [NI];
    int   n_acc     [NI];
    int   n_done    [NI];
    int   n_miss    [NI];
    int   n_stall   [NI];
    logic [7:0]  s_lx [NI], s_px [NI], a_lx [NI];
    logic [8:0]  s_ly [NI], s_py [NI], a_ly [NI];
    logic [15:0] s_ld [NI], a_ld [NI];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            bit acc_now;
            bit nb;
            int ex;
            int ey;
            chk("busy", i, busy[i], m_busy[i]);
            chk("frame_done", i, done[i], m_done[i]);
            chk("frame_missed", i, miss[i], m_miss[i]);
            chk("write_outside_frame", i, lw[i] && !m_busy[i], 1'b0);
            if (done[i]) begin
                n_done[i]++;
                frame_len[i] = cyc - busy_cyc[i];
            end
            if (miss[i]) n_miss[i]++;
            if (m_zero[i]) begin
                chk("rst_lcd_write", i, lw[i], 0);
                chk("rst_pixel_xy", i, {px[i], py[i]}, 0);
                chk("rst_lcd_xy", i, {lx[i], ly[i]}, 0);
                chk("rst_lcd_data", i, ld[i], 0);
            end
            acc_now = 1'b0;
            if (lw[i]) begin
                if (m_stall[i]) begin
                    chk("hold_lcd_xy", i, {lx[i], ly[i]}, {s_lx[i], s_ly[i]});
                    chk("hold_lcd_data", i, ld[i], s_ld[i]);
                    chk("hold_pixel_xy", i, {px[i], py[i]}, {s_px[i], s_py[i]});
                end
                if (rdy[i]) begin
                    ex = k[i] % CFG_W[i];
                    ey = k[i] / CFG_W[i];
                    chk("wr_x", i, lx[i], ex);
                    chk("wr_y", i, ly[i], ey);
                    chk("wr_data", i, ld[i], {ey[7:0], ex[7:0]});
                    chk("wr_pixel_xy", i, {px[i], py[i]}, {ex[7:0], ey[8:0]});
                    if (m_clean[i]) begin
                        if (k[i] == 0) chk("first_latency", i, cyc - busy_cyc[i], CFG_L[i] + 1);
                        else chk("pixel_period", i, cyc - last_acc[i], CFG_L[i] + 2);
                    end
                    last_acc[i] = cyc;
                    m_clean[i]  = 1'b1;
                    m_stall[i]  = 1'b0;
                    k[i]++;
                    n_acc[i]++;
                    a_lx[i] = lx[i];
                    a_ly[i] = ly[i];
                    a_ld[i] = ld[i];
                    acc_now = 1'b1;
                end else begin
                    s_lx[i] = lx[i];
                    s_ly[i] = ly[i];
                    s_ld[i] = ld[i];
                    s_px[i] = px[i];
                    s_py[i] = py[i];
                    m_stall[i] = 1'b1;
                    m_clean[i] = 1'b0;
                    n_stall[i]++;
                end
            end else if (m_stall[i]) begin
                chk("write_dropped", i, lw[i], 1'b1);
                m_stall[i] = 1'b0;
            end
            // Advance the model to what the next cycle must show.
            nb        = m_busy[i];
            m_miss[i] = fs[i] && m_busy[i];
            m_done[i] = 1'b0;
            if (acc_now && (k[i] == CFG_W[i] * CFG_H[i])) begin
                nb        = 1'b0;
                m_done[i] = 1'b1;
            end
            if (fs[i] && !m_busy[i]) begin
                nb           = 1'b1;
                k[i]         = 0;
                busy_cyc[i]  = cyc + 1;
                m_clean[i]   = 1'b1;
                n_acc[i]     = 0;
                n_done[i]    = 0;
                n_miss[i]    = 0;
                n_stall[i]   = 0;
                frame_len[i] = 0;
            end
            m_zero[i] = 1'b0;
            if (!rst_n[i]) begin
                nb         = 1'b0;
                m_done[i]  = 1'b0;
                m_miss[i]  = 1'b0;
                m_zero[i]  = 1'b1;
                m_stall[i] = 1'b0;
                k[i]       = 0;
            end
            m_busy[i] = nb;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        fs[i] = 1'b1;
        step();
        fs[i] = 1'b0;
    endtask

    task automatic wait_px(input int i, input int x, input int y, input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (px[i] == x[7:0] && py[i] == y[8:0]) return;
        end
        expired("wait_pixel", i);
    endtask

    task automatic wait_write(input int i, input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (lw[i]) return;
        end
        expired("wait_write", i);
    endtask

    task automatic wait_done_pin(input int i, input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (done[i]) return;
        end
        expired("wait_done_pin", i);
    endtask

    task automatic wait_done(input int i, input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (n_done[i] > 0) return;
        end
        expired("wait_done", i);
    endtask

    task automatic wait_acc(input int i, input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (n_acc[i] >= n) return;
        end
        expired("wait_accepts", i);
    endtask

    task automatic check_small_frame(input int len, input int misses, input int stalls);
        chk("t_accepts", 0, n_acc[0], 12);
        chk("t_frame_len", 0, frame_len[0], len);
        chk("t_done_count", 0, n_done[0], 1);
        chk("t_missed_count", 0, n_miss[0], misses);
        chk("t_stall_cycles", 0, n_stall[0], stalls);
        chk("t_last_xy", 0, {a_lx[0], a_ly[0]}, {8'd3, 9'd2});
        chk("t_last_data", 0, a_ld[0], 16'h0203);
        chk("t_busy_after", 0, busy[0], 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0;
            fs[i]    = 1'b1;
            rdy[i]   = 1'b1;
        end
        // 1: reset held two cycles with frame_start high
        step();
        step();
        chk("t1_state", 0, dut_s.r_state, StIdle);
        chk("t1_busy", 0, busy[0], 1'b0);
        chk("t1_write", 0, lw[0], 1'b0);
        chk("t1_missed", 0, miss[0], 1'b0);
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b1;
            fs[i]    = 1'b0;
        end
        step();

        // 2: plain 4x3 frame, then a restart in the frame_done cycle
        pulse_start(0);
        wait_done(0, 200);
        check_small_frame(36, 0, 0);
        step();
        pulse_start(0);
        wait_done_pin(0, 200);
        pulse_start(0);
        wait_done(0, 200);
        check_small_frame(36, 0, 0);
        repeat (3) step();

        // 3: five cycles of backpressure at pixel (2,1)
        pulse_start(0);
        wait_px(0, 2, 1, 200);
        rdy[0] = 1'b0;
        wait_write(0, 20);
        repeat (5) step();
        rdy[0] = 1'b1;
        wait_done(0, 200);
        check_small_frame(41, 0, 5);
        step();

        // 4: overrun request at pixel (1,0)
        pulse_start(0);
        wait_px(0, 1, 0, 200);
        pulse_start(0);
        wait_done(0, 200);
        check_small_frame(36, 1, 0);
        step();

        // 5: reset mid-frame at pixel (1,1), then a clean restart
        pulse_start(0);
        wait_px(0, 1, 1, 200);
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        chk("t5_busy", 0, busy[0], 1'b0);
        chk("t5_write", 0, lw[0], 1'b0);
        chk("t5_pixel_xy", 0, {px[0], py[0]}, 0);
        chk("t5_lcd_data", 0, ld[0], 0);
        step();
        pulse_start(0);
        wait_done(0, 200);
        check_small_frame(36, 0, 0);

        // 6a: default geometry, line wrap from (239,0) to (0,1)
        pulse_start(1);
        wait_acc(1, 240, 1200);
        chk("t6_wrap_last_xy", 1, {a_lx[1], a_ly[1]}, {8'd239, 9'd0});
        chk("t6_wrap_last_data", 1, a_ld[1], 16'h00EF);
        wait_acc(1, 241, 100);
        chk("t6_wrap_next_xy", 1, {a_lx[1], a_ly[1]}, {8'd0, 9'd1});
        chk("t6_wrap_next_data", 1, a_ld[1], 16'h0100);
        chk("t6_busy_mid", 1, busy[1], 1'b1);
        chk("t6_no_done_yet", 1, n_done[1], 0);
        rst_n[1] = 1'b0;
        step();
        rst_n[1] = 1'b1;
        chk("t6_reset_busy", 1, busy[1], 1'b0);

        // 6b: full 240-wide frame, latency 0
        pulse_start(2);
        wait_done(2, 3000);
        chk("t6_accepts", 2, n_acc[2], 960);
        chk("t6_frame_len", 2, frame_len[2], 1920);
        chk("t6_done_count", 2, n_done[2], 1);
        chk("t6_last_xy", 2, {a_lx[2], a_ly[2]}, {8'd239, 9'd3});
        chk("t6_last_data", 2, a_ld[2], 16'h03EF);
        repeat (4) step();
        chk("t6_done_once", 2, n_done[2], 1);
        chk("t6_busy_after", 2, busy[2], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
